// File: rtl/vga_640x480_timing.sv
// 640x480@60 VGA timing: divides clock_50M by two and runs pixel/line counters on the
// divided phase, with sync, display-enable and frame strobe decoded from the counters.
module vga_640x480_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clock_50M,
    input  logic       reset_n,
    output logic       clock_25M,
    output logic       pix_en,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame
);

    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic          phase_q, phase_d;
    logic [CW-1:0] sx_q, sx_d;
    logic [CW-1:0] sy_q, sy_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          frame_q, frame_d;

    // Next counter values; decodes are taken from the next values so the
    // registered sync/enable outputs line up with sx/sy with no extra latency.
    always_comb begin
        phase_d = ~phase_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (phase_q) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == V_LAST) ? '0 : sy_q + CW'(1);
            end else begin
                sx_d = sx_q + CW'(1);
            end
        end
        hsync_d = !((sx_d >= HS_START) && (sx_d < HS_END));
        vsync_d = !((sy_d >= VS_START) && (sy_d < VS_END));
        de_d    = (sx_d < H_VIS) && (sy_d < V_VIS);
        frame_d = (sy_d == V_VIS) && (sx_d == '0);
    end

    // Reset values are the decode of counters at (0,0).
    always_ff @(posedge clock_50M) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            frame_q <= frame_d;
        end
    end

    assign clock_25M = phase_q;
    assign pix_en    = phase_q;
    assign sx        = sx_q;
    assign sy        = sy_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign frame     = frame_q;

endmodule

// File: tb/tb_vga_640x480_timing.sv
// Bench for vga_640x480_timing: a full-size instance for line timing and a shrunken
// instance (16x10 total) for frame wrap, frame counts and mid-frame reset.
module tb_vga_640x480_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_s;

    logic       c25_m, pe_m, hs_m, vs_m, de_m, fr_m;
    logic [9:0] sx_m, sy_m;
    logic       c25_s, pe_s, hs_s, vs_s, de_s, fr_s;
    logic [9:0] sx_s, sy_s;

    vga_640x480_timing dut_m (
        .clock_50M(clk), .reset_n(rst_m), .clock_25M(c25_m), .pix_en(pe_m),
        .sx(sx_m), .sy(sy_m), .hsync(hs_m), .vsync(vs_m), .de(de_m), .frame(fr_m)
    );

    vga_640x480_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clock_50M(clk), .reset_n(rst_s), .clock_25M(c25_s), .pix_en(pe_s),
        .sx(sx_s), .sy(sy_s), .hsync(hs_s), .vsync(vs_s), .de(de_s), .frame(fr_s)
    );

    // Expected state after the k-th clock edge since reset (k=0 is the reset state):
    // advances happen on even edges, so the pixel index is k/2.
    function automatic logic [25:0] model(input int unsigned k,
                                          input int unsigned ha, input int unsigned hf,
                                          input int unsigned hs, input int unsigned hb,
                                          input int unsigned va, input int unsigned vf,
                                          input int unsigned vs, input int unsigned vb);
        int unsigned adv, ht, vt, x, y;
        logic ph;
        adv = k / 2;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        x   = adv % ht;
        y   = (adv / ht) % vt;
        ph  = (k % 2) == 1;
        return {ph, ph, 10'(x), 10'(y),
                !(x >= ha + hf && x < ha + hf + hs),
                !(y >= va + vf && y < va + vf + vs),
                (x < ha) && (y < va),
                (y == va) && (x == 0)};
    endfunction

    logic [25:0] q_m[$];
    logic [25:0] q_s[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got c25=%b pe=%b sx=%0d sy=%0d hs=%b vs=%b de=%b fr=%b, want c25=%b pe=%b sx=%0d sy=%0d hs=%b vs=%b de=%b fr=%b",
                     name, $time, act[25], act[24], act[23:14], act[13:4], act[3], act[2], act[1], act[0],
                     exp[25], exp[24], exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new state every clock; pop and compare mid-cycle.
    always @(negedge clk) begin
        if (q_m.size() > 0)
            check("main", {c25_m, pe_m, sx_m, sy_m, hs_m, vs_m, de_m, fr_m}, q_m.pop_front());
        if (q_s.size() > 0)
            check("small", {c25_s, pe_s, sx_s, sy_s, hs_s, vs_s, de_s, fr_s}, q_s.pop_front());
    end

    // Event counters over a window chosen by the driver.
    logic cnt_m_en = 1'b0, cnt_s_en = 1'b0;
    int hlow_m = 0, depix_m = 0;
    int pix_s = 0, depix_s = 0, hfall_s = 0, vfall_s = 0, fr_cyc_s = 0;
    logic hs_prev_s = 1'b1, vs_prev_s = 1'b1;

    always @(negedge clk) begin
        if (cnt_m_en) begin
            if (!hs_m) hlow_m++;
            if (pe_m && de_m) depix_m++;
        end
        if (cnt_s_en) begin
            if (pe_s) pix_s++;
            if (pe_s && de_s) depix_s++;
            if (hs_prev_s && !hs_s) hfall_s++;
            if (vs_prev_s && !vs_s) vfall_s++;
            if (fr_s) fr_cyc_s++;
        end
        hs_prev_s = hs_s;
        vs_prev_s = vs_s;
    end

    int unsigned k_m, k_s;
    bit mid_done;

    initial begin
        rst_m = 1'b0;
        rst_s = 1'b0;
        k_m = 0;
        k_s = 0;
        mid_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            q_m.push_back(model(0, 640, 16, 96, 48, 480, 10, 2, 33));
            q_s.push_back(model(0, 8, 2, 3, 3, 6, 1, 2, 1));
        end
        #1 rst_m = 1'b1;
        rst_s = 1'b1;

        for (int c = 0; c < 20400; c++) begin
            @(posedge clk);
            k_m++;
            if (!rst_s) k_s = 0;
            else k_s++;
            q_m.push_back(model(k_m, 640, 16, 96, 48, 480, 10, 2, 33));
            q_s.push_back(model(k_s, 8, 2, 3, 3, 6, 1, 2, 1));
            cnt_m_en = (k_m >= 1) && (k_m <= 1600);
            cnt_s_en = (k_s >= 1) && (k_s <= 320) && !mid_done;
            // One-cycle reset of the small instance at sx=5, sy=3 of its second frame.
            if (k_s == 426 && !mid_done) begin
                mid_done = 1'b1;
                #1 rst_s = 1'b0;
            end else if (!rst_s) begin
                #1 rst_s = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        cnt_m_en = 1'b0;
        cnt_s_en = 1'b0;

        check_cnt("line_hsync_low_cycles", hlow_m, 192);
        check_cnt("line_de_pixels", depix_m, 640);
        check_cnt("frame_pix_en", pix_s, 160);
        check_cnt("frame_de_pixels", depix_s, 48);
        check_cnt("frame_hsync_pulses", hfall_s, 10);
        check_cnt("frame_vsync_pulses", vfall_s, 1);
        check_cnt("frame_strobe_cycles", fr_cyc_s, 2);
        check_cnt("queues_drained", q_m.size() + q_s.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
